// File: rtl/pwm_multi_channel_if.sv
// Config/status bundle between a control block and the multi-channel PWM.
// master = config side, slave = PWM engine.
interface pwm_multi_channel_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
);
    logic                      en;
    logic                      load;
    logic [CNT_W-1:0]          period;
    logic [NUM_CH*CNT_W-1:0]   duty;
    logic                      center_mode;
    logic [NUM_CH-1:0]         pwm_out;
    logic [CNT_W-1:0]          cnt;
    logic                      period_end;
    logic                      load_ack;

    modport master (
        output en, load, period, duty, center_mode,
        input  pwm_out, cnt, period_end, load_ack
    );

    modport slave (
        input  en, load, period, duty, center_mode,
        output pwm_out, cnt, period_end, load_ack
    );
endinterface

// File: rtl/pwm_multi_channel.sv
// NUM_CH-channel PWM sharing one edge/center-aligned period counter, with
// double-buffered period/duty/mode that only switch at a period boundary.

module pwm_lane #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             idle,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] duty,
    output logic             pwm
);
    always_ff @(posedge clk) begin
        if (!rst_n) pwm <= 1'b0;
        else        pwm <= !idle && (cnt < duty);
    end
endmodule

module pwm_multi_channel #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pwm_multi_channel_if.slave    bus
);
    typedef enum logic {DIR_UP, DIR_DN} dir_t;

    logic [NUM_CH-1:0][CNT_W-1:0] duty_in;
    logic [NUM_CH-1:0][CNT_W-1:0] stg_d, act_d;
    logic [CNT_W-1:0]             stg_p, act_p;
    logic                         stg_mode, act_mode;
    logic                         pending, ack_q;
    logic [CNT_W-1:0]             cnt_q, cnt_nxt;
    dir_t                         dir_q, dir_nxt;
    logic                         idle, pe, apply;
    logic [NUM_CH-1:0]            pwm_q;

    assign duty_in = bus.duty;

    assign idle  = !bus.en || (act_p == '0);
    assign pe    = !idle && (act_mode ? (cnt_q == '0 && dir_q == DIR_DN)
                                      : (cnt_q == act_p - CNT_W'(1)));
    // A boundary with either a fresh load or a parked one swaps the active set.
    assign apply = (pe || idle) && (bus.load || pending);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            dir_q <= DIR_UP;
        end else begin
            cnt_q <= cnt_nxt;
            dir_q <= dir_nxt;
        end
    end

    // Center mode holds the end value for one extra cycle while direction flips.
    always_comb begin
        cnt_nxt = cnt_q;
        dir_nxt = dir_q;
        if (idle || pe) begin
            cnt_nxt = '0;
            dir_nxt = DIR_UP;
        end else if (!act_mode) begin
            cnt_nxt = cnt_q + CNT_W'(1);
        end else begin
            case (dir_q)
                DIR_UP: begin
                    if (cnt_q == act_p - CNT_W'(1)) dir_nxt = DIR_DN;
                    else                            cnt_nxt = cnt_q + CNT_W'(1);
                end
                DIR_DN: begin
                    if (cnt_q == '0) dir_nxt = DIR_UP;
                    else             cnt_nxt = cnt_q - CNT_W'(1);
                end
                default: dir_nxt = DIR_UP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stg_p    <= '0;
            stg_d    <= '0;
            stg_mode <= 1'b0;
            act_p    <= '0;
            act_d    <= '0;
            act_mode <= 1'b0;
            pending  <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            if (bus.load) begin
                stg_p    <= bus.period;
                stg_d    <= duty_in;
                stg_mode <= bus.center_mode;
            end
            if (apply) begin
                act_p    <= bus.load ? bus.period      : stg_p;
                act_d    <= bus.load ? duty_in         : stg_d;
                act_mode <= bus.load ? bus.center_mode : stg_mode;
                pending  <= 1'b0;
            end else if (bus.load) begin
                pending  <= 1'b1;
            end
            ack_q <= apply;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        pwm_lane #(.CNT_W(CNT_W)) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .idle (idle),
            .cnt  (cnt_q),
            .duty (act_d[i]),
            .pwm  (pwm_q[i])
        );
    end

    assign bus.pwm_out    = pwm_q;
    assign bus.cnt        = cnt_q;
    assign bus.period_end = pe;
    assign bus.load_ack   = ack_q;
endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed bench for pwm_multi_channel: reset, edge/center modes, shadow
// updates, back-to-back loads and idle loads.
module tb_pwm_multi_channel;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pwm_multi_channel_if #(.NUM_CH(4), .CNT_W(16)) bus ();

    pwm_multi_channel #(.NUM_CH(4), .CNT_W(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_cfg(input int p, input int d3, input int d2, input int d1,
                           input int d0, input logic mode);
        bus.period      = 16'(p);
        bus.duty        = {16'(d3), 16'(d2), 16'(d1), 16'(d0)};
        bus.center_mode = mode;
        bus.load        = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int h0, h1, h2, h3, pe_n, ha, hb, hc, ack_n;

        // reset with active-looking inputs
        rst_n  = 1'b0;
        bus.en = 1'b1;
        set_cfg(10, 15, 10, 0, 3, 1'b0);
        repeat (3) tick();
        chk("rst_cnt", 32'(bus.cnt), 0);
        chk("rst_pwm", 32'(bus.pwm_out), 0);
        chk("rst_pe",  32'(bus.period_end), 0);
        chk("rst_ack", 32'(bus.load_ack), 0);
        rst_n    = 1'b1;
        bus.load = 1'b0;
        repeat (3) tick();
        chk("post_rst_cnt", 32'(bus.cnt), 0);
        chk("post_rst_pwm", 32'(bus.pwm_out), 0);
        chk("post_rst_ack", 32'(bus.load_ack), 0);

        // edge mode P=10, D={15,10,0,3}
        set_cfg(10, 15, 10, 0, 3, 1'b0);
        tick();
        bus.load = 1'b0;
        chk("e_ack", 32'(bus.load_ack), 1);
        chk("e_cnt0", 32'(bus.cnt), 0);
        h0 = 0; h1 = 0; h2 = 0; h3 = 0; pe_n = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            h0 += bus.pwm_out[0]; h1 += bus.pwm_out[1];
            h2 += bus.pwm_out[2]; h3 += bus.pwm_out[3];
            pe_n += bus.period_end;
            if (k == 9) begin
                chk("e_cnt9", 32'(bus.cnt), 9);
                chk("e_pe9", 32'(bus.period_end), 1);
            end
            if (k == 10) chk("e_pwm_k10", 32'(bus.pwm_out[0]), 0);
            if (k == 11) chk("e_pwm_k11", 32'(bus.pwm_out[0]), 1);
        end
        chk("e_h0", h0, 6);
        chk("e_h1", h1, 0);
        chk("e_h2", h2, 20);
        chk("e_h3", h3, 20);
        chk("e_pe_n", pe_n, 2);

        // center mode P=8, D0=2, loaded while idle
        bus.en = 1'b0;
        set_cfg(8, 0, 0, 0, 2, 1'b1);
        tick();
        bus.load = 1'b0;
        bus.en   = 1'b1;
        chk("c_ack", 32'(bus.load_ack), 1);
        h0 = 0; pe_n = 0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            h0 += bus.pwm_out[0];
            pe_n += bus.period_end;
            if (k == 8) chk("c_cnt8", 32'(bus.cnt), 7);
            if (k == 9) chk("c_cnt9", 32'(bus.cnt), 6);
            if (k == 15) begin
                chk("c_cnt15", 32'(bus.cnt), 0);
                chk("c_pe15", 32'(bus.period_end), 1);
            end
            if (k == 16) begin
                chk("c_pwm16", 32'(bus.pwm_out[0]), 1);
                chk("c_pe16", 32'(bus.period_end), 0);
            end
        end
        chk("c_h0", h0, 8);
        chk("c_pe_n", pe_n, 2);

        // mid-period update: D0 3 -> 7 at cnt=4
        bus.en = 1'b0;
        set_cfg(10, 0, 0, 0, 3, 1'b0);
        tick();
        bus.load = 1'b0;
        bus.en   = 1'b1;
        ha = 0; hb = 0; ack_n = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k <= 10) ha += bus.pwm_out[0];
            else         hb += bus.pwm_out[0];
            ack_n += bus.load_ack;
            if (k == 10) chk("m_ack10", 32'(bus.load_ack), 1);
            if (k == 4) begin
                bus.load       = 1'b1;
                bus.duty[15:0] = 16'd7;
            end
            if (k == 5) bus.load = 1'b0;
        end
        chk("m_old", ha, 3);
        chk("m_new", hb, 7);
        chk("m_ack_n", ack_n, 1);

        // back-to-back loads, then a load on the period_end cycle
        bus.en = 1'b0;
        set_cfg(10, 0, 0, 0, 3, 1'b0);
        tick();
        bus.load = 1'b0;
        bus.en   = 1'b1;
        ha = 0; hb = 0; hc = 0; ack_n = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k <= 10)      ha += bus.pwm_out[0];
            else if (k <= 20) hb += bus.pwm_out[0];
            else              hc += bus.pwm_out[0];
            ack_n += bus.load_ack;
            if (k == 10) chk("b_ack10", 32'(bus.load_ack), 1);
            if (k == 19) chk("b_pe19", 32'(bus.period_end), 1);
            if (k == 20) chk("b_ack20", 32'(bus.load_ack), 1);
            if (k == 2)  begin bus.load = 1'b1; bus.duty[15:0] = 16'd5; end
            if (k == 3)  bus.load = 1'b0;
            if (k == 6)  begin bus.load = 1'b1; bus.duty[15:0] = 16'd8; end
            if (k == 7)  bus.load = 1'b0;
            if (k == 19) begin bus.load = 1'b1; bus.duty[15:0] = 16'd2; end
            if (k == 20) bus.load = 1'b0;
        end
        chk("b_w1", ha, 3);
        chk("b_w2", hb, 8);
        chk("b_w3", hc, 2);
        chk("b_ack_n", ack_n, 2);

        // en drops mid-period, load while idle, mode input toggled without load
        repeat (3) tick();
        chk("i_mid_cnt", 32'(bus.cnt), 3);
        bus.en = 1'b0;
        set_cfg(4, 0, 0, 0, 2, 1'b0);
        tick();
        bus.load = 1'b0;
        chk("i_ack", 32'(bus.load_ack), 1);
        chk("i_cnt", 32'(bus.cnt), 0);
        chk("i_pwm", 32'(bus.pwm_out), 0);
        bus.center_mode = 1'b1;
        repeat (2) tick();
        chk("i_pwm2", 32'(bus.pwm_out), 0);
        chk("i_cnt2", 32'(bus.cnt), 0);
        chk("i_pe2", 32'(bus.period_end), 0);
        chk("i_ack2", 32'(bus.load_ack), 0);
        bus.en = 1'b1;
        h0 = 0; pe_n = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            h0 += bus.pwm_out[0];
            pe_n += bus.period_end;
            if (k == 3) chk("i_cnt_k3", 32'(bus.cnt), 3);
            if (k == 4) chk("i_cnt_k4", 32'(bus.cnt), 0);
        end
        chk("i_h0", h0, 4);
        chk("i_pe_n", pe_n, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
